// File: rtl/riscv_pipe_pkg.sv
//============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared pipeline definitions for the ID/EX boundary.
//               Holds the control bundle width, the bit position of every
//               control flag, the ALU operation codes and the bubble
//               control word.
//               Control bundle layout, MSB first:
//               {regwrite, memread, memwrite, memtoreg, alusrc, aluop[3:0]}
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package riscv_pipe_pkg;

    localparam int CTRL_W        = 9;

    // Bit positions inside the control bundle
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 4;

    // ALU operation codes carried in aluop
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD    = 4'd0;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB    = 4'd1;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_RTYPE  = 4'd2;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ITYPE  = 4'd3;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_BRANCH = 4'd4;

    // Bubble control word: no write, no memory access
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Register-index geometry
    localparam int               REG_ADDR_W = 5;
    localparam logic [4:0]       REG_ZERO   = 5'd0;

endpackage

`default_nettype wire

// File: rtl/loaduse_detect.sv
//============================================================================
// Module      : loaduse_detect
// Description : Combinational load-use hazard detector. Flags the case
//               where the instruction in EX is a load whose destination
//               is read by the valid instruction currently in ID.
//               x0 is never a hazard because it is hardwired to zero.
// Ports       : i_id_valid      - ID holds a real instruction
//               i_id_uses_rs2   - ID instruction reads rs2
//               i_id_rs1/rs2    - ID source register indices
//               i_ex_valid      - EX holds a real instruction
//               i_ex_memread    - EX instruction is a load
//               i_ex_rd         - EX destination register index
//               o_lu            - load-use hazard present
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module loaduse_detect
    import riscv_pipe_pkg::*;
(
    input  logic                  i_id_valid,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    output logic                  o_lu
);

    logic w_ex_is_load;
    logic w_rs1_match;
    logic w_rs2_match;

    assign w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rd != REG_ZERO);
    assign w_rs1_match  = (i_ex_rd == i_id_rs1);
    // rs2 only matters for instruction formats that actually read it
    assign w_rs2_match  = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);

    assign o_lu = i_id_valid & w_ex_is_load & (w_rs1_match | w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/idex_stage.sv
//============================================================================
// Module      : idex_stage
// Description : ID/EX pipeline register with load-use stall generation,
//               flush and global hold. Edge priority:
//               reset > flush > hold > load-use bubble > normal load.
//               Optional performance counters enabled by the macro
//               IDEX_PERF_CNT_EN; when undefined the counter ports read 0.
// Ports       : in_clk, in_rst            - clock, sync active-high reset
//               in_flush                  - kill instruction entering EX
//               in_hold                   - freeze all state
//               in_id_*                   - decoded ID instruction
//               out_ex_*                  - registered ID/EX contents
//               out_stall                 - load-use stall to PC and IF/ID
//               out_loaduse_cnt           - load-use bubbles inserted
//               out_flush_cnt             - flush edges seen
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module idex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_flush,
    input  logic              in_hold,
    input  logic              in_id_valid,
    input  logic              in_id_uses_rs2,
    input  logic [XLEN-1:0]   in_id_pc,
    input  logic [XLEN-1:0]   in_id_rs1_data,
    input  logic [XLEN-1:0]   in_id_rs2_data,
    input  logic [XLEN-1:0]   in_id_imm,
    input  logic [4:0]        in_id_rs1,
    input  logic [4:0]        in_id_rs2,
    input  logic [4:0]        in_id_rd,
    input  logic [CTRL_W-1:0] in_id_ctrl,
    output logic              out_ex_valid,
    output logic [XLEN-1:0]   out_ex_pc,
    output logic [XLEN-1:0]   out_ex_rs1_data,
    output logic [XLEN-1:0]   out_ex_rs2_data,
    output logic [XLEN-1:0]   out_ex_imm,
    output logic [4:0]        out_ex_rs1,
    output logic [4:0]        out_ex_rs2,
    output logic [4:0]        out_ex_rd,
    output logic [CTRL_W-1:0] out_ex_ctrl,
    output logic              out_stall,
    output logic [15:0]       out_loaduse_cnt,
    output logic [15:0]       out_flush_cnt
);

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_rs1_data;
    logic [XLEN-1:0]   r_ex_rs2_data;
    logic [XLEN-1:0]   r_ex_imm;
    logic [4:0]        r_ex_rs1;
    logic [4:0]        r_ex_rs2;
    logic [4:0]        r_ex_rd;
    logic [CTRL_W-1:0] r_ex_ctrl;

    logic w_lu;
    logic w_bubble;
    logic w_load;

    loaduse_detect u_loaduse_detect (
        .i_id_valid    (in_id_valid),
        .i_id_uses_rs2 (in_id_uses_rs2),
        .i_id_rs1      (in_id_rs1),
        .i_id_rs2      (in_id_rs2),
        .i_ex_valid    (r_ex_valid),
        .i_ex_memread  (r_ex_ctrl[riscv_pipe_pkg::CTRL_MEMREAD]),
        .i_ex_rd       (r_ex_rd),
        .o_lu          (w_lu)
    );

    // A flush already removes the offending load's consumer path, so the
    // stall is suppressed and the front end may advance to the new target.
    assign out_stall = w_lu & ~in_flush;

    // Flush wins over hold. Otherwise, with hold released, a hazard or an
    // invalid ID slot both load an all-zero entry: zero rd/rs1/rs2 can
    // never match a forwarding path or write the register file.
    assign w_bubble = in_flush | (~in_hold & (w_lu | ~in_id_valid));
    assign w_load   = ~in_hold;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= '0;
        end else if (w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_ctrl     <= '0;
        end else if (w_load) begin
            r_ex_valid    <= in_id_valid;
            r_ex_pc       <= in_id_pc;
            r_ex_rs1_data <= in_id_rs1_data;
            r_ex_rs2_data <= in_id_rs2_data;
            r_ex_imm      <= in_id_imm;
            r_ex_rs1      <= in_id_rs1;
            r_ex_rs2      <= in_id_rs2;
            r_ex_rd       <= in_id_rd;
            r_ex_ctrl     <= in_id_ctrl;
        end
    end

    assign out_ex_valid    = r_ex_valid;
    assign out_ex_pc       = r_ex_pc;
    assign out_ex_rs1_data = r_ex_rs1_data;
    assign out_ex_rs2_data = r_ex_rs2_data;
    assign out_ex_imm      = r_ex_imm;
    assign out_ex_rs1      = r_ex_rs1;
    assign out_ex_rs2      = r_ex_rs2;
    assign out_ex_rd       = r_ex_rd;
    assign out_ex_ctrl     = r_ex_ctrl;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] r_loaduse_cnt;
    logic [15:0] r_flush_cnt;

    // A flush is counted even under hold; a load-use bubble only happens
    // (and is only counted) when neither flush nor hold is active.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_loaduse_cnt <= 16'h0000;
            r_flush_cnt   <= 16'h0000;
        end else if (in_flush) begin
            if (r_flush_cnt != 16'hFFFF) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end else if (!in_hold && w_lu) begin
            if (r_loaduse_cnt != 16'hFFFF) begin
                r_loaduse_cnt <= r_loaduse_cnt + 16'd1;
            end
        end
    end

    assign out_loaduse_cnt = r_loaduse_cnt;
    assign out_flush_cnt   = r_flush_cnt;
`else
    assign out_loaduse_cnt = 16'h0000;
    assign out_flush_cnt   = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idex_stage.sv
`default_nettype none

module tb_idex_stage;

    localparam logic [8:0] LW   = 9'h1B0; // regwrite|memread|memtoreg|alusrc, add
    localparam logic [8:0] ADD  = 9'h102; // regwrite, R-type
    localparam logic [8:0] ADDI = 9'h113; // regwrite|alusrc, I-type
`ifdef IDEX_PERF_CNT_EN
    localparam logic [15:0] CNT_ON = 16'd1;
`else
    localparam logic [15:0] CNT_ON = 16'd0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } ent_t;

    logic        clk, rst, flush, hold, id_valid, id_uses_rs2;
    logic [31:0] id_pc, id_r1d, id_r2d, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [8:0]  id_ctrl;
    logic        ex_valid, stall;
    logic [31:0] ex_pc, ex_r1d, ex_r2d, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [8:0]  ex_ctrl;
    logic [15:0] lu_cnt, fl_cnt;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    idex_stage #(.XLEN(32), .CTRL_W(9)) dut (
        .in_clk(clk), .in_rst(rst), .in_flush(flush), .in_hold(hold),
        .in_id_valid(id_valid), .in_id_uses_rs2(id_uses_rs2),
        .in_id_pc(id_pc), .in_id_rs1_data(id_r1d), .in_id_rs2_data(id_r2d),
        .in_id_imm(id_imm), .in_id_rs1(id_rs1), .in_id_rs2(id_rs2),
        .in_id_rd(id_rd), .in_id_ctrl(id_ctrl),
        .out_ex_valid(ex_valid), .out_ex_pc(ex_pc), .out_ex_rs1_data(ex_r1d),
        .out_ex_rs2_data(ex_r2d), .out_ex_imm(ex_imm), .out_ex_rs1(ex_rs1),
        .out_ex_rs2(ex_rs2), .out_ex_rd(ex_rd), .out_ex_ctrl(ex_ctrl),
        .out_stall(stall), .out_loaduse_cnt(lu_cnt), .out_flush_cnt(fl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t        m_ex;
    logic [15:0] m_lc, m_fc;

    function automatic ent_t id_entry();
        ent_t e;
        e = '{id_valid, id_pc, id_r1d, id_r2d, id_imm, id_rs1, id_rs2, id_rd, id_ctrl};
        return e;
    endfunction

    // EX holds a load to a nonzero register that the valid ID instruction reads
    function automatic logic m_hazard();
        return id_valid && m_ex.valid && m_ex.ctrl[7] && (m_ex.rd != 5'd0) &&
               ((m_ex.rd == id_rs1) || (id_uses_rs2 && m_ex.rd == id_rs2));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge clk) begin
        logic h;
        h = m_hazard();
        if (rst) begin
            m_ex = '0; m_lc = 16'd0; m_fc = 16'd0;
        end else if (flush) begin
            m_ex = '0; m_fc = sat_inc(m_fc);
        end else if (!hold) begin
            if (h) begin
                m_ex = '0; m_lc = sat_inc(m_lc);
            end else if (!id_valid) begin
                m_ex = '0;
            end else begin
                m_ex = id_entry();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_entry", {ex_valid, ex_pc, ex_r1d, ex_r2d, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl}, m_ex);
            chk("stall", stall, m_hazard() && !flush);
            chk("loaduse_cnt", lu_cnt, (CNT_ON != 0) ? m_lc : 16'd0);
            chk("flush_cnt", fl_cnt, (CNT_ON != 0) ? m_fc : 16'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic u, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [8:0] c, input logic [31:0] pcv);
        id_valid = v; id_uses_rs2 = u; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_ctrl = c; id_pc = pcv; id_r1d = pcv ^ 32'h1111_0000;
        id_r2d = pcv + 32'd7; id_imm = pcv >> 2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        drive_id(0, 0, 0, 0, 0, 9'h0, 32'h0);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);

        // load x5 enters EX
        drive_id(1, 0, 2, 0, 5, LW, 32'h100);
        tick();
        chk("load_rd", ex_rd, 5'd5);
        chk("load_ctrl", ex_ctrl, LW);

        // dependent add: stall, one bubble, then add loads
        drive_id(1, 1, 5, 6, 7, ADD, 32'h104);
        #1 chk("lu_stall", stall, 1'b1);
        tick();
        chk("bubble_valid", ex_valid, 1'b0);
        chk("bubble_ctrl", ex_ctrl, 9'h0);
        chk("after_bubble_stall", stall, 1'b0);
        chk("lu_cnt_1", lu_cnt, CNT_ON);
        tick();
        chk("add_rd", ex_rd, 5'd7);
        chk("add_pc", ex_pc, 32'h104);

        // rs2 matches but not used: no hazard
        drive_id(1, 1, 2, 0, 5, LW, 32'h108);
        tick();
        drive_id(1, 0, 3, 5, 8, ADD, 32'h10c);
        #1 chk("no_rs2_stall", stall, 1'b0);
        tick();
        chk("no_rs2_rd", ex_rd, 5'd8);

        // load to x0 never stalls
        drive_id(1, 0, 1, 0, 0, LW, 32'h110);
        tick();
        drive_id(1, 1, 0, 0, 9, ADD, 32'h114);
        #1 chk("x0_stall", stall, 1'b0);
        tick();

        // hazard with flush: no stall, one bubble, counts as flush only
        drive_id(1, 0, 2, 0, 5, LW, 32'h118);
        tick();
        drive_id(1, 0, 5, 0, 10, ADD, 32'h11c);
        flush = 1'b1;
        #1 chk("flush_stall", stall, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_cnt_1", fl_cnt, CNT_ON);
        chk("flush_lu_cnt", lu_cnt, CNT_ON);

        // hold three cycles with changing ID data, then release
        drive_id(1, 0, 3, 4, 11, ADDI, 32'h120);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 1, 5'(i), 5'(i + 1), 5'(12 + i), ADD, 32'h200 + 32'(4 * i));
            tick();
            chk("hold_pc", ex_pc, 32'h120);
        end
        hold = 1'b0;
        tick();
        chk("release_pc", ex_pc, 32'h208);

        // hazard under hold: stall asserted, nothing changes, nothing counted
        drive_id(1, 0, 2, 0, 5, LW, 32'h20c);
        tick();
        drive_id(1, 0, 5, 0, 13, ADD, 32'h210);
        hold = 1'b1;
        #1 chk("hold_lu_stall", stall, 1'b1);
        tick();
        tick();
        chk("hold_lu_pc", ex_pc, 32'h20c);
        chk("hold_lu_cnt", lu_cnt, CNT_ON);
        hold = 1'b0;
        tick();
        chk("hold_lu_bubble", ex_valid, 1'b0);
        chk("lu_cnt_2", lu_cnt, 16'(2 * CNT_ON));
        tick();

        // flush while held still counts and bubbles
        drive_id(1, 0, 1, 2, 14, ADD, 32'h214);
        hold = 1'b1; flush = 1'b1;
        tick();
        hold = 1'b0; flush = 1'b0;
        chk("hold_flush_valid", ex_valid, 1'b0);
        chk("flush_cnt_2", fl_cnt, 16'(2 * CNT_ON));

        // back-to-back loads to the same rd
        drive_id(1, 0, 2, 0, 5, LW, 32'h218);
        tick();
        drive_id(1, 0, 5, 0, 5, LW, 32'h21c);
        #1 chk("b2b_stall_1", stall, 1'b1);
        tick();
        tick();
        drive_id(1, 0, 5, 0, 6, ADD, 32'h220);
        #1 chk("b2b_stall_2", stall, 1'b1);
        tick();
        tick();

        // invalid ID slot loads an empty entry
        drive_id(0, 1, 7, 8, 9, LW, 32'h300);
        tick();
        chk("invalid_valid", ex_valid, 1'b0);
        chk("invalid_ctrl", ex_ctrl, 9'h0);

        // reset asserted in the middle of a stall
        drive_id(1, 0, 2, 0, 5, LW, 32'h304);
        tick();
        drive_id(1, 0, 5, 0, 7, ADD, 32'h308);
        #1 chk("pre_rst_stall", stall, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", ex_valid, 1'b0);
        chk("rst_mid_rd", ex_rd, 5'd0);
        chk("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_lu_cnt", lu_cnt, 16'd0);
        chk("rst_mid_fl_cnt", fl_cnt, 16'd0);
        rst = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, default 9, control bundle width {regwrite, memread, memwrite, memtoreg, alusrc, aluop[3:0]}, MSB first.
REQ-003 in_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 in_rst  input  1  reset, synchronous, active-high.
REQ-005 in_flush  input  1  kill instruction entering EX (taken branch/jump resolved in EX).
REQ-006 in_hold  input  1  global stall (memory wait), freeze all state.
REQ-007 in_id_valid  input  1  ID holds a real instruction.
REQ-008 in_id_uses_rs2  input  1  ID instruction reads rs2 (R/S/B type).
REQ-009 in_id_pc, in_id_rs1_data, in_id_rs2_data, in_id_imm  input  XLEN each  ID operands.
REQ-010 in_id_rs1, in_id_rs2, in_id_rd  input  5 each  register indices.
REQ-011 in_id_ctrl  input  CTRL_W  decoded control bundle.
REQ-012 out_ex_valid  output  1; out_ex_pc, out_ex_rs1_data, out_ex_rs2_data, out_ex_imm  output  XLEN; out_ex_rs1, out_ex_rs2, out_ex_rd  output  5; out_ex_ctrl  output  CTRL_W; all registered ID/EX contents.
REQ-013 out_stall  output  1  combinational load-use stall to PC and IF/ID register (hold).
REQ-014 out_loaduse_cnt, out_flush_cnt  output  16 each  event counters (see Configuration).

Function
REQ-015 Per rising edge, action priority SHALL be: in_rst > in_flush > in_hold > load-use bubble > normal load.
REQ-016 Load-use hazard (LU) SHALL be: in_id_valid & out_ex_valid & out_ex_ctrl.memread & out_ex_rd!=0 & (out_ex_rd==in_id_rs1 | (in_id_uses_rs2 & out_ex_rd==in_id_rs2)).
REQ-017 out_stall SHALL equal LU & !in_flush, zero latency, no registered component.
REQ-018 Normal load SHALL copy every in_id_* field to its out_ex_* counterpart; out_ex_valid<=in_id_valid; latency 1 cycle.
REQ-019 Bubble (flush or LU) SHALL set out_ex_valid, out_ex_ctrl, out_ex_rd, out_ex_rs1, out_ex_rs2 and all XLEN fields to 0.
REQ-020 Zeroed rs1/rs2/rd in a bubble SHALL guarantee no forwarding match downstream and no register write.
REQ-021 in_hold (without flush) SHALL retain all out_ex_* values, even when LU is true; out_stall still follows REQ-017.
REQ-022 LU stall SHALL last exactly one cycle: after the bubble out_ex_ctrl.memread=0 so LU clears unless in_hold.
REQ-023 in_flush with LU SHALL insert one bubble, deassert out_stall, count as flush only.
REQ-024 in_id_valid=0 SHALL load a bubble-equivalent entry (valid 0, ctrl 0) regardless of other fields.
REQ-025 Back-to-back loads to same rd SHALL each be evaluated independently against the current EX entry.

Reset
REQ-026 On in_rst at an edge all out_ex_* SHALL become 0, both counters 0, independent of flush/hold.
REQ-027 out_stall SHALL be 0 in the cycle after reset (EX empty), even if reset asserted mid-stall.

Configuration
REQ-028 Macro IDEX_PERF_CNT_EN defined: out_loaduse_cnt increments per LU bubble, out_flush_cnt per flush edge, not while in_hold (except flush), saturating at 16'hFFFF.
REQ-029 Macro IDEX_PERF_CNT_EN undefined: both counter ports present and tied to 0, no counter flops.

Structure
REQ-030 Shared package riscv_pipe_pkg SHALL hold CTRL_W, ctrl bit positions (CTRL_REGWRITE..CTRL_ALUOP), aluop codes, bubble constant CTRL_NOP=0.
REQ-031 Sub-module loaduse_detect (combinational, computes LU) SHALL be instantiated once; remainder is register logic in idex_stage.

Verification
REQ-032 Load x5 in EX (memread=1, rd=5), ID add rs1=5 valid -> out_stall=1 same cycle; next edge out_ex_valid=0, ctrl=0; following cycle out_stall=0, add loads.
REQ-033 Same, but ID uses_rs2=0 and rs2=5, rs1=3 -> out_stall=0, normal load.
REQ-034 Load rd=0 in EX, ID rs1=0 -> out_stall=0.
REQ-035 LU plus in_flush=1 -> out_stall=0, bubble loaded, out_flush_cnt +1, out_loaduse_cnt unchanged (macro on).
REQ-036 in_hold=1 for 3 cycles with new ID data -> out_ex_* unchanged; release -> new data in 1 cycle.
REQ-037 in_rst asserted during LU stall -> next edge all outputs 0, counters 0, out_stall=0.
